// File: rtl/block_dispatcher_pkg.sv
// Shared constants and FSM encoding for the kernel-launch block dispatcher.
package block_dispatcher_pkg;

    // Width of the instruction-memory address space (kernel start PC).
    localparam int INSTMEM_ADDR_WIDTH = 8;

    // Default width of a grid dimension / block index, matching the Scheduler.
    localparam int DIM_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_DONE     = 2'd3
    } disp_state_e;

endpackage

// File: rtl/block_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, with wrap.
module block_dispatcher_rr_arbiter #(
    parameter int N = 4,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             valid_o
);

    logic [PTR_W:0] idx;

    // Scan candidates in priority order starting at the pointer.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        idx         = '0;
        for (int i = 0; i < N; i++) begin
            idx = {1'b0, ptr_i} + (PTR_W + 1)'(i);
            if (idx >= (PTR_W + 1)'(N)) begin
                idx = idx - (PTR_W + 1)'(N);
            end
            if (!valid_o && req_i[idx[PTR_W-1:0]]) begin
                valid_o                  = 1'b1;
                grant_idx_o              = idx[PTR_W-1:0];
                grant_o[idx[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/block_dispatcher.sv
// Kernel-launch front end: walks a 3-D grid and hands block indices to idle SM cores.
module block_dispatcher
    import block_dispatcher_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int DIM_W     = DIM_W_DEFAULT,
    parameter int ADDR_W    = INSTMEM_ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 launch_valid,
    output logic                 launch_ready,
    input  logic [ADDR_W-1:0]    launch_addr,
    input  logic [DIM_W-1:0]     grid_x,
    input  logic [DIM_W-1:0]     grid_y,
    input  logic [DIM_W-1:0]     grid_z,
    output logic [NUM_CORES-1:0] disp_valid,
    input  logic [NUM_CORES-1:0] disp_ready,
    output logic [DIM_W-1:0]     disp_x,
    output logic [DIM_W-1:0]     disp_y,
    output logic [DIM_W-1:0]     disp_z,
    output logic [ADDR_W-1:0]    disp_addr,
    input  logic [NUM_CORES-1:0] core_done,
    output logic                 busy,
    output logic                 kernel_done
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    disp_state_e          state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DIM_W-1:0]     gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
    logic [DIM_W-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
    logic [NUM_CORES-1:0] active_q, active_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 hold_q, hold_d;
    logic [PTR_W-1:0]     hold_core_q, hold_core_d;

    logic [NUM_CORES-1:0] arb_grant;
    logic [PTR_W-1:0]     arb_idx;
    logic                 arb_valid;
    logic [PTR_W-1:0]     cur_core;
    logic                 cur_valid;
    logic                 accept;
    logic                 last_idx;

    // Idle cores request; a core freed this cycle only requests next cycle.
    block_dispatcher_rr_arbiter #(
        .N (NUM_CORES)
    ) u_arb (
        .req_i       (~active_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .valid_o     (arb_valid)
    );

    // A pending offer is frozen on its core until accepted.
    assign cur_core  = hold_q ? hold_core_q : arb_idx;
    assign cur_valid = (state_q == ST_DISPATCH) && (hold_q || arb_valid);
    assign accept    = cur_valid && disp_ready[cur_core];
    assign last_idx  = (x_q == gx_q - ONE) && (y_q == gy_q - ONE) && (z_q == gz_q - ONE);

    assign disp_valid   = (state_q != ST_DISPATCH) ? '0 :
                          hold_q ? (NUM_CORES'(1) << hold_core_q) : arb_grant;
    assign disp_x       = x_q;
    assign disp_y       = y_q;
    assign disp_z       = z_q;
    assign disp_addr    = addr_q;
    assign busy         = (state_q != ST_IDLE);
    assign launch_ready = (state_q == ST_IDLE);
    assign kernel_done  = (state_q == ST_DONE);

    // Next-state logic: launch capture, dispatch/index walk, drain and done.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        gx_d        = gx_q;
        gy_d        = gy_q;
        gz_d        = gz_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        active_d    = active_q & ~core_done;
        rr_ptr_d    = rr_ptr_q;
        hold_d      = hold_q;
        hold_core_d = hold_core_q;

        case (state_q)
            ST_IDLE: begin
                if (launch_valid) begin
                    addr_d = launch_addr;
                    gx_d   = grid_x;
                    gy_d   = grid_y;
                    gz_d   = grid_z;
                    x_d    = '0;
                    y_d    = '0;
                    z_d    = '0;
                    if ((grid_x == '0) || (grid_y == '0) || (grid_z == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                if (accept) begin
                    active_d[cur_core] = 1'b1;
                    rr_ptr_d = (cur_core == PTR_W'(NUM_CORES - 1)) ? '0 : cur_core + PTR_W'(1);
                    hold_d   = 1'b0;
                    if (x_q == gx_q - ONE) begin
                        x_d = '0;
                        if (y_q == gy_q - ONE) begin
                            y_d = '0;
                            z_d = (z_q == gz_q - ONE) ? '0 : z_q + ONE;
                        end else begin
                            y_d = y_q + ONE;
                        end
                    end else begin
                        x_d = x_q + ONE;
                    end
                    if (last_idx) begin
                        state_d = ST_DRAIN;
                    end
                end else if (cur_valid) begin
                    hold_d      = 1'b1;
                    hold_core_d = cur_core;
                end
            end
            ST_DRAIN: begin
                if (active_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any kernel in flight.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            gx_q        <= '0;
            gy_q        <= '0;
            gz_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            active_q    <= '0;
            rr_ptr_q    <= '0;
            hold_q      <= 1'b0;
            hold_core_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            gx_q        <= gx_d;
            gy_q        <= gy_d;
            gz_q        <= gz_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            active_q    <= active_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_q      <= hold_d;
            hold_core_q <= hold_core_d;
        end
    end

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench: randomized cores against a queue-based dispatch model.
module tb_block_dispatcher;

    localparam int NC = 4;
    localparam int DW = 4;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          launch_valid;
    logic          launch_ready;
    logic [AW-1:0] launch_addr;
    logic [DW-1:0] grid_x, grid_y, grid_z;
    logic [NC-1:0] disp_valid, disp_ready, core_done;
    logic [DW-1:0] disp_x, disp_y, disp_z;
    logic [AW-1:0] disp_addr;
    logic          busy, kernel_done;

    block_dispatcher #(.NUM_CORES(NC), .DIM_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .launch_valid (launch_valid),
        .launch_ready (launch_ready),
        .launch_addr  (launch_addr),
        .grid_x       (grid_x),
        .grid_y       (grid_y),
        .grid_z       (grid_z),
        .disp_valid   (disp_valid),
        .disp_ready   (disp_ready),
        .disp_x       (disp_x),
        .disp_y       (disp_y),
        .disp_z       (disp_z),
        .disp_addr    (disp_addr),
        .core_done    (core_done),
        .busy         (busy),
        .kernel_done  (kernel_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: which cores hold a block, where round-robin resumes, any frozen offer.
    int rr_m   = 0;
    int held_m = -1;
    bit busy_m[NC];
    int done_at[NC];
    int release_at[NC];

    // Core behaviour policy.
    int ready_pct   = 100;
    int stall_core  = -1;
    int stall_until = 0;
    int lat_min     = 3;
    int lat_max     = 3;
    int spur_pct    = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        rr_m   = 0;
        held_m = -1;
        for (int c = 0; c < NC; c++) busy_m[c] = 1'b0;
    endtask

    task automatic set_policy(input int rp, input int sc, input int su,
                              input int lmin, input int lmax, input int sp);
        ready_pct   = rp;
        stall_core  = sc;
        stall_until = su;
        lat_min     = lmin;
        lat_max     = lmax;
        spur_pct    = sp;
        for (int c = 0; c < NC; c++) release_at[c] = 0;
    endtask

    // Launch one kernel and check every cycle until the IDLE cycle after kernel_done.
    task automatic run_kernel(input string name, input logic [AW-1:0] a,
                              input int gx, input int gy, input int gz, input bit spam);
        int qx[$], qy[$], qz[$];
        int last_done = -1;
        int kd_cyc    = -1;
        int start;
        int exp_core;
        bit exp_v;
        bit all_idle;
        bit done_now[NC];
        logic [NC-1:0] exp_oh;
        logic [3*DW+AW-1:0] exp_pl;

        for (int z = 0; z < gz; z++)
            for (int y = 0; y < gy; y++)
                for (int x = 0; x < gx; x++) begin
                    qx.push_back(x);
                    qy.push_back(y);
                    qz.push_back(z);
                end

        tick();
        n_cmp++;
        if (launch_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s launch_ready: got %b expected 1", name, launch_ready);
        end
        launch_valid = 1'b1;
        launch_addr  = a;
        grid_x       = DW'(gx);
        grid_y       = DW'(gy);
        grid_z       = DW'(gz);
        start        = cyc;

        while (cyc < start + 3000) begin
            tick();
            if (spam && kd_cyc < 0) begin
                launch_valid = 1'b1;
                launch_addr  = AW'($urandom);
                grid_x       = DW'($urandom);
                grid_y       = DW'($urandom);
                grid_z       = DW'($urandom);
            end else begin
                launch_valid = 1'b0;
            end
            for (int c = 0; c < NC; c++) begin
                done_now[c]   = busy_m[c] && (cyc == done_at[c]);
                core_done[c]  = done_now[c] || (!busy_m[c] && ($urandom_range(99) < spur_pct));
                disp_ready[c] = (c == stall_core && cyc < stall_until) ? 1'b0 :
                                ($urandom_range(99) < ready_pct);
            end
            #1;

            if (kd_cyc >= 0) begin
                n_cmp++;
                if ({busy, launch_ready, kernel_done, disp_valid} !== {1'b0, 1'b1, 1'b0, {NC{1'b0}}}) begin
                    n_bad++;
                    $display("FAIL %s idle_after_done: busy/ready/kdone/valid got %b%b%b%b expected 0100000",
                             name, busy, launch_ready, kernel_done, disp_valid);
                end
                break;
            end

            exp_v    = 1'b0;
            exp_core = -1;
            if (qx.size() > 0) begin
                if (held_m >= 0) begin
                    exp_v    = 1'b1;
                    exp_core = held_m;
                end else begin
                    for (int i = 0; i < NC; i++) begin
                        int c;
                        c = (rr_m + i) % NC;
                        if (!exp_v && !busy_m[c]) begin
                            exp_v    = 1'b1;
                            exp_core = c;
                        end
                    end
                end
            end
            exp_oh = exp_v ? (NC'(1) << exp_core) : '0;

            n_cmp++;
            if (disp_valid !== exp_oh) begin
                n_bad++;
                $display("FAIL %s disp_valid @%0d: got %b expected %b", name, cyc, disp_valid, exp_oh);
            end
            if (exp_v) begin
                exp_pl = {DW'(qx[0]), DW'(qy[0]), DW'(qz[0]), a};
                n_cmp++;
                if ({disp_x, disp_y, disp_z, disp_addr} !== exp_pl) begin
                    n_bad++;
                    $display("FAIL %s payload @%0d: got %h expected %h", name, cyc,
                             {disp_x, disp_y, disp_z, disp_addr}, exp_pl);
                end
            end
            n_cmp++;
            if (busy !== 1'b1 || launch_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s busy @%0d: busy/ready got %b%b expected 10", name, cyc, busy, launch_ready);
            end
            if (kernel_done === 1'b1) kd_cyc = cyc;

            for (int c = 0; c < NC; c++) if (done_now[c]) busy_m[c] = 1'b0;
            if (exp_v) begin
                if (disp_ready[exp_core]) begin
                    void'(qx.pop_front());
                    void'(qy.pop_front());
                    void'(qz.pop_front());
                    busy_m[exp_core]  = 1'b1;
                    done_at[exp_core] = cyc + int'($urandom_range(lat_max, lat_min));
                    if (done_at[exp_core] < release_at[exp_core]) done_at[exp_core] = release_at[exp_core];
                    rr_m   = (exp_core + 1) % NC;
                    held_m = -1;
                end else begin
                    held_m = exp_core;
                end
            end
            all_idle = 1'b1;
            for (int c = 0; c < NC; c++) if (busy_m[c]) all_idle = 1'b0;
            if (last_done < 0 && qx.size() == 0 && all_idle) last_done = cyc;
        end

        n_cmp++;
        if (kd_cyc < 0) begin
            n_bad++;
            $display("FAIL %s kernel_done timeout: got none expected pulse at %0d", name, last_done + 2);
        end else if (kd_cyc != last_done + 2) begin
            n_bad++;
            $display("FAIL %s kernel_done timing: got cycle %0d expected %0d", name, kd_cyc, last_done + 2);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            launch_valid = 1'($urandom);
            launch_addr  = AW'($urandom);
            grid_x       = DW'($urandom);
            grid_y       = DW'($urandom);
            grid_z       = DW'($urandom);
            disp_ready   = NC'($urandom);
            core_done    = NC'($urandom);
            #1;
            n_cmp++;
            if ({disp_valid, busy, kernel_done, disp_x, disp_y, disp_z, disp_addr} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold: got %h expected 0",
                         {disp_valid, busy, kernel_done, disp_x, disp_y, disp_z, disp_addr});
            end
        end
        tick();
        launch_valid = 1'b0;
        disp_ready   = '0;
        core_done    = '0;
        reset        = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (launch_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: ready/busy got %b%b expected 10", launch_ready, busy);
        end
    endtask

    task automatic test_basic();
        set_policy(100, -1, 0, 3, 3, 0);
        run_kernel("basic_2x2x1", 8'h10, 2, 2, 1, 1'b0);
    endtask

    task automatic test_ready_stall();
        set_policy(100, 0, cyc + 10, 3, 3, 0);
        run_kernel("stall_3x1x1", 8'h44, 3, 1, 1, 1'b0);
    endtask

    task automatic test_no_idle_core();
        set_policy(100, -1, 0, 1, 1, 0);
        for (int c = 0; c < NC; c++) release_at[c] = cyc + 30;
        release_at[2] = cyc + 15;
        run_kernel("no_idle_6x1x1", 8'h5a, 6, 1, 1, 1'b0);
    endtask

    task automatic test_zero_grid();
        for (int d = 0; d < 3; d++) begin
            tick();
            n_cmp++;
            if (launch_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL zero_grid%0d launch_ready: got %b expected 1", d, launch_ready);
            end
            launch_valid = 1'b1;
            launch_addr  = AW'($urandom);
            grid_x       = (d == 0) ? '0 : DW'($urandom_range(15, 1));
            grid_y       = (d == 1) ? '0 : DW'($urandom_range(15, 1));
            grid_z       = (d == 2) ? '0 : DW'($urandom_range(15, 1));
            disp_ready   = '1;
            core_done    = '0;
            tick();
            launch_valid = 1'b0;
            #1;
            n_cmp++;
            if ({busy, kernel_done, disp_valid} !== {1'b1, 1'b1, {NC{1'b0}}}) begin
                n_bad++;
                $display("FAIL zero_grid%0d done_cycle: busy/kdone/valid got %b%b%b expected 110000",
                         d, busy, kernel_done, disp_valid);
            end
            tick();
            #1;
            n_cmp++;
            if ({busy, kernel_done, disp_valid, launch_ready} !== {1'b0, 1'b0, {NC{1'b0}}, 1'b1}) begin
                n_bad++;
                $display("FAIL zero_grid%0d idle: busy/kdone/valid/ready got %b%b%b%b expected 0000001",
                         d, busy, kernel_done, disp_valid, launch_ready);
            end
        end
    endtask

    task automatic test_launch_ignored();
        set_policy(70, -1, 0, 1, 4, 20);
        run_kernel("launch_spam_3x2x1", 8'h77, 3, 2, 1, 1'b1);
    endtask

    task automatic test_reset_mid_kernel();
        int first;
        tick();
        launch_valid = 1'b1;
        launch_addr  = 8'h3c;
        grid_x       = 4'd8;
        grid_y       = 4'd1;
        grid_z       = 4'd1;
        core_done    = '0;
        disp_ready   = '1;
        first        = rr_m;
        for (int k = 0; k < 2; k++) begin
            tick();
            launch_valid = 1'b0;
            #1;
            n_cmp++;
            if (disp_valid !== (NC'(1) << ((first + k) % NC)) || disp_x !== DW'(k)) begin
                n_bad++;
                $display("FAIL reset_mid dispatch%0d: valid/x got %b/%0d expected %b/%0d", k,
                         disp_valid, disp_x, NC'(1) << ((first + k) % NC), k);
            end
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({busy, disp_valid, kernel_done, disp_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid abandon: got %h expected 0", {busy, disp_valid, kernel_done, disp_addr});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            n_cmp++;
            if (kernel_done !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_mid kernel_done: got %b expected 0", kernel_done);
            end
        end
        tick();
        reset = 1'b1;
        model_reset();
        set_policy(100, -1, 0, 3, 3, 0);
        run_kernel("after_reset_4x1x1", 8'h21, 4, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            set_policy($urandom_range(100, 30), -1, 0, 1, $urandom_range(6, 1), $urandom_range(30, 0));
            run_kernel($sformatf("random%0d", k), AW'($urandom),
                       $urandom_range(3, 1), $urandom_range(3, 1), $urandom_range(3, 1), 1'b0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        launch_valid = 1'b0;
        launch_addr  = '0;
        grid_x       = '0;
        grid_y       = '0;
        grid_z       = '0;
        disp_ready   = '0;
        core_done    = '0;
        #2;
        test_reset();
        test_basic();
        test_ready_stall();
        test_no_idle_core();
        test_zero_grid();
        test_launch_ignored();
        test_reset_mid_kernel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish before 900000");
        $fatal(1, "watchdog expired");
    end

endmodule
